// File: rtl/diff_commit_checker_if.sv
// diff_commit_checker_if: difftest commit-event bundle plus the checker's error report.
// master drives commit events and observes errors; slave is the checker side.
interface diff_commit_checker_if #(
  parameter int unsigned XLEN = 64
) ();
  logic              instrValid;
  logic [XLEN-1:0]   the_pc;
  logic [31:0]       instr;
  logic              skip;
  logic              wen;
  logic [7:0]        wdest;
  logic [XLEN-1:0]   wdata;
  logic              excp_valid;
  logic              isMret;
  logic [XLEN-1:0]   mtvec;
  logic [XLEN-1:0]   mepc;
  logic [7:0]        storeValid;
  logic [32*XLEN-1:0] gprFlat;

  logic              errValid;
  logic              errSticky;
  logic [3:0]        errCode;
  logic [XLEN-1:0]   errPc;
  logic [63:0]       commitCnt;

  modport master (
    output instrValid, the_pc, instr, skip, wen, wdest, wdata,
    output excp_valid, isMret, mtvec, mepc, storeValid, gprFlat,
    input  errValid, errSticky, errCode, errPc, commitCnt
  );

  modport slave (
    input  instrValid, the_pc, instr, skip, wen, wdest, wdata,
    input  excp_valid, isMret, mtvec, mepc, storeValid, gprFlat,
    output errValid, errSticky, errCode, errPc, commitCnt
  );
endinterface

// File: rtl/diff_commit_checker.sv
// diff_commit_checker: in-hardware self-consistency checker for the difftest commit stream.
// Checks x0 writes, destination range, PC sequencing, trap/mret redirect targets and store
// pairing; the first violation is latched with its code, PC and the accepted-commit count.
// Optional build macro DIFF_SHADOW_GPR_EN adds a shadow register file compared against gprFlat.
module diff_commit_checker #(
  parameter int unsigned XLEN = 64
) (
  input logic                  clock,
  input logic                  reset,
  diff_commit_checker_if.slave bus
);

  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [3:0] ErrNone        = 4'd0;
  localparam logic [3:0] ErrX0Write     = 4'd1;
  localparam logic [3:0] ErrBadDest     = 4'd2;
  localparam logic [3:0] ErrPcSeq       = 4'd3;
  localparam logic [3:0] ErrTrapTgt     = 4'd4;
  localparam logic [3:0] ErrMretTgt     = 4'd5;
  localparam logic [3:0] ErrStoreOrphan = 4'd6;
  localparam logic [3:0] ErrStoreMiss   = 4'd7;
  localparam logic [3:0] ErrGprMismatch = 4'd8;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StTrapPend,
    StMretPend,
    StHalt
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   prev_pc_q;
  logic              prev_ctl_q;
  logic [XLEN-1:0]   mtvec_q;
  logic [XLEN-1:0]   mepc_q;
  logic              err_valid_q;
  logic              err_sticky_q;
  logic [3:0]        err_code_q;
  logic [XLEN-1:0]   err_pc_q;
  logic [63:0]       commit_cnt_q;

  logic [6:0]        opcode;
  logic              commit;
  logic              is_store;
  logic              is_ctl;
  logic              store_evt;
  logic [XLEN-1:0]   seq_pc;
  logic [XLEN-1:0]   trap_pc;
  logic              gpr_err;
  logic [XLEN-1:0]   gpr_err_pc;
  logic [3:0]        err_code_c;
  logic [XLEN-1:0]   err_pc_c;

  assign opcode    = bus.instr[6:0];
  // Nothing is checked or counted once halted.
  assign commit    = bus.instrValid & (state_q != StHalt);
  assign is_store  = (opcode == OpStore);
  assign is_ctl    = (opcode == OpBranch) | (opcode == OpJal) |
                     (opcode == OpJalr) | (opcode == OpSystem);
  assign store_evt = (bus.storeValid != 8'd0);
  assign seq_pc    = prev_pc_q + XLEN'(4);
  // Trap vector uses direct mode: low two mode bits are ignored.
  assign trap_pc   = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef DIFF_SHADOW_GPR_EN
  logic [XLEN-1:0] shadow_q [1:31];
  logic            cmp_pend_q;
  logic [XLEN-1:0] cmp_pc_q;
  logic            unused_sig;

  assign unused_sig = ^{bus.instr[31:7], bus.skip};

  // Shadow file tracks retired GPR writes; a compare is armed for the cycle after any commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        shadow_q[i] <= '0;
      end
      cmp_pend_q <= 1'b0;
      cmp_pc_q   <= '0;
    end else begin
      cmp_pend_q <= commit;
      if (commit) begin
        cmp_pc_q <= bus.the_pc;
      end
      if (commit && bus.wen && (bus.wdest != 8'd0) && (bus.wdest < 8'd32)) begin
        shadow_q[bus.wdest[4:0]] <= bus.wdata;
      end
    end
  end

  // Architectural file must equal the shadow copy, with x0 hardwired to zero.
  always_comb begin
    gpr_err = 1'b0;
    if (cmp_pend_q) begin
      if (bus.gprFlat[XLEN-1:0] != '0) begin
        gpr_err = 1'b1;
      end
      for (int i = 1; i < 32; i++) begin
        if (bus.gprFlat[i*XLEN +: XLEN] != shadow_q[i]) begin
          gpr_err = 1'b1;
        end
      end
    end
  end

  assign gpr_err_pc = cmp_pc_q;
`else
  logic unused_sig;

  assign gpr_err    = 1'b0;
  assign gpr_err_pc = '0;
  assign unused_sig = ^{bus.instr[31:7], bus.skip, bus.wdata, bus.gprFlat};
`endif

  // Error classification; the cascade order makes the lowest code win.
  always_comb begin
    err_code_c = ErrNone;
    err_pc_c   = bus.the_pc;
    if (state_q != StHalt) begin
      if (commit && bus.wen && (bus.wdest == 8'd0)) begin
        err_code_c = ErrX0Write;
      end else if (commit && bus.wen && (bus.wdest > 8'd31)) begin
        err_code_c = ErrBadDest;
      end else if (commit && (state_q == StRun) && !prev_ctl_q && (bus.the_pc != seq_pc)) begin
        err_code_c = ErrPcSeq;
      end else if (commit && (state_q == StTrapPend) && (bus.the_pc != trap_pc)) begin
        err_code_c = ErrTrapTgt;
      end else if (commit && (state_q == StMretPend) && (bus.the_pc != mepc_q)) begin
        err_code_c = ErrMretTgt;
      end else if (store_evt && !(commit && is_store)) begin
        err_code_c = ErrStoreOrphan;
      end else if (commit && is_store && !store_evt) begin
        err_code_c = ErrStoreMiss;
      end else if (gpr_err) begin
        err_code_c = ErrGprMismatch;
        err_pc_c   = gpr_err_pc;
      end
    end
  end

  // Checker FSM with registered error report; a trap on a commit is applied after its checks.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      prev_pc_q    <= '0;
      prev_ctl_q   <= 1'b0;
      mtvec_q      <= '0;
      mepc_q       <= '0;
      err_valid_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_code_q   <= ErrNone;
      err_pc_q     <= '0;
      commit_cnt_q <= '0;
    end else begin
      err_valid_q <= 1'b0;
      if (state_q != StHalt) begin
        if (err_code_c != ErrNone) begin
          state_q      <= StHalt;
          err_valid_q  <= 1'b1;
          err_sticky_q <= 1'b1;
          err_code_q   <= err_code_c;
          err_pc_q     <= err_pc_c;
        end else begin
          if (commit) begin
            commit_cnt_q <= commit_cnt_q + 64'd1;
            prev_pc_q    <= bus.the_pc;
            prev_ctl_q   <= is_ctl;
          end
          if (bus.excp_valid) begin
            // A newer redirect replaces any target still pending.
            if (bus.isMret) begin
              mepc_q  <= bus.mepc;
              state_q <= StMretPend;
            end else begin
              mtvec_q <= bus.mtvec;
              state_q <= StTrapPend;
            end
          end else if (commit) begin
            state_q <= StRun;
          end
        end
      end
    end
  end

  assign bus.errValid  = err_valid_q;
  assign bus.errSticky = err_sticky_q;
  assign bus.errCode   = err_code_q;
  assign bus.errPc     = err_pc_q;
  assign bus.commitCnt = commit_cnt_q;

endmodule

// File: tb/tb_diff_commit_checker.sv
// tb_diff_commit_checker: table-driven directed vectors, randomized commits against a
// rule-level reference model, and a few hand-written multi-cycle sequences.
module tb_diff_commit_checker;
  localparam int unsigned XLEN = 64;
  localparam logic [31:0] IAddi  = 32'h00000013;
  localparam logic [31:0] ISw    = 32'h00002023;
  localparam logic [31:0] IJal   = 32'h0000006f;
  localparam logic [31:0] IEcall = 32'h00000073;
  localparam logic [31:0] IMret  = 32'h30200073;

  typedef struct packed {
    logic        iv;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        sk;
    logic        wen;
    logic [7:0]  wd;
    logic [63:0] wdata;
    logic        ex;
    logic        mret;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    logic [7:0]  sv;
  } ev_t;

  typedef struct packed {
    logic        rst;
    ev_t         e;
    logic        v;
    logic        s;
    logic [3:0]  c;
    logic [63:0] p;
    logic [63:0] n;
  } row_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  diff_commit_checker_if #(.XLEN(XLEN)) bus ();
  diff_commit_checker #(.XLEN(XLEN)) dut (.clock(clock), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Architectural register file as a core would expose it on gprFlat.
  logic [63:0] arch [32];
  bit          freeze_arch = 1'b0;

  // Reference model: rule-level view of the commit stream.
  bit          m_halt, m_seen, m_pend, m_prev_ctl, m_ev;
  logic [63:0] m_prev_pc, m_tgt, m_epc, m_cnt;
  logic [3:0]  m_tcode, m_ecode;

  row_t tbl[$];

  function automatic ev_t mk(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                             input logic wen, input logic [7:0] wd, input logic ex,
                             input logic mret, input logic [63:0] tv, input logic [63:0] ep,
                             input logic [7:0] sv);
    ev_t e;
    e = '0;
    e.iv = iv; e.pc = pc; e.ins = ins; e.wen = wen; e.wd = wd; e.wdata = 64'h1111;
    e.ex = ex; e.mret = mret; e.mtvec = tv; e.mepc = ep; e.sv = sv;
    return e;
  endfunction

  function automatic ev_t cm(input logic [63:0] pc, input logic [31:0] ins);
    return mk(1'b1, pc, ins, 1'b0, 8'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
  endfunction

  task automatic add(input logic rst, input ev_t e, input logic v, input logic s,
                     input logic [3:0] c, input logic [63:0] p, input logic [63:0] n);
    row_t r;
    r.rst = rst; r.e = e; r.v = v; r.s = s; r.c = c; r.p = p; r.n = n;
    tbl.push_back(r);
  endtask

  task automatic model_reset();
    m_halt = 0; m_seen = 0; m_pend = 0; m_prev_ctl = 0; m_ev = 0;
    m_prev_pc = '0; m_tgt = '0; m_epc = '0; m_cnt = '0; m_tcode = '0; m_ecode = '0;
  endtask

  task automatic model_step(input ev_t e);
    int hits[$];
    int code;
    bit st, ctl;
    st  = (e.ins[6:0] == 7'b0100011);
    ctl = e.ins[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011};
    m_ev = 0;
    if (m_halt) return;
    if (e.iv && e.wen && e.wd == 8'd0) hits.push_back(1);
    if (e.iv && e.wen && e.wd > 8'd31) hits.push_back(2);
    if (e.iv && m_seen && !m_pend && !m_prev_ctl && e.pc != m_prev_pc + 64'd4) hits.push_back(3);
    if (e.iv && m_pend && e.pc != m_tgt) hits.push_back(int'(m_tcode));
    if (e.sv != 0 && !(e.iv && st)) hits.push_back(6);
    if (e.iv && st && e.sv == 0) hits.push_back(7);
    code = 0;
    foreach (hits[k]) if (code == 0 || hits[k] < code) code = hits[k];
    if (code != 0) begin
      m_halt = 1; m_ev = 1; m_ecode = 4'(code); m_epc = e.pc;
      return;
    end
    if (e.iv) begin
      m_cnt = m_cnt + 64'd1; m_prev_pc = e.pc; m_prev_ctl = ctl; m_seen = 1; m_pend = 0;
    end
    if (e.ex) begin
      m_pend = 1;
      if (e.mret) begin
        m_tgt = e.mepc; m_tcode = 4'd5;
      end else begin
        m_tgt = {e.mtvec[63:2], 2'b00}; m_tcode = 4'd4;
      end
    end
  endtask

  task automatic apply(input ev_t e, input logic rst);
    logic [32*XLEN-1:0] g;
    @(negedge clock);
    for (int i = 0; i < 32; i++) g[i*64 +: 64] = arch[i];
    reset = rst;
    bus.instrValid = e.iv; bus.the_pc = e.pc; bus.instr = e.ins; bus.skip = e.sk;
    bus.wen = e.wen; bus.wdest = e.wd; bus.wdata = e.wdata;
    bus.excp_valid = e.ex; bus.isMret = e.mret; bus.mtvec = e.mtvec; bus.mepc = e.mepc;
    bus.storeValid = e.sv; bus.gprFlat = g;
    if (rst) model_reset();
    else model_step(e);
    @(posedge clock);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) arch[i] = '0;
    end else if (!freeze_arch && e.iv && e.wen && e.wd != 0 && e.wd < 32) begin
      arch[e.wd[4:0]] = e.wdata;
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic s, input logic [3:0] c,
                           input logic [63:0] p, input logic [63:0] n);
    cmp({tag, ".errValid"}, 64'(bus.errValid), 64'(v));
    cmp({tag, ".errSticky"}, 64'(bus.errSticky), 64'(s));
    cmp({tag, ".errCode"}, 64'(bus.errCode), 64'(c));
    cmp({tag, ".errPc"}, bus.errPc, p);
    cmp({tag, ".commitCnt"}, bus.commitCnt, n);
  endtask

  function automatic ev_t gen();
    ev_t e;
    int unsigned k;
    e = '0;
    e.iv = ($urandom_range(0, 9) != 0);
    k = $urandom_range(0, 4);
    e.ins = (k == 2) ? ISw : (k == 3) ? IJal : (k == 4) ? IEcall : IAddi;
    if (m_pend && $urandom_range(0, 9) != 0) e.pc = m_tgt;
    else if ($urandom_range(0, 9) != 0) e.pc = m_prev_pc + 64'd4;
    else e.pc = {32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom} & ~64'd3;
    e.sk = 1'($urandom);
    e.wen = ($urandom_range(0, 9) < 4);
    e.wd = ($urandom_range(0, 19) != 0) ? 8'($urandom_range(1, 31)) : 8'($urandom_range(0, 40));
    e.wdata = {$urandom, $urandom};
    e.ex = (e.ins == IEcall) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
    e.mret = e.ex && ($urandom_range(0, 2) == 0);
    e.mtvec = {32'h8000_0000, $urandom};
    e.mepc = {32'h8000_0000, $urandom & 32'hffff_fffc};
    if (e.iv && e.ins == ISw) e.sv = ($urandom_range(0, 19) != 0) ? 8'($urandom_range(1, 255)) : 8'd0;
    else e.sv = ($urandom_range(0, 29) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
    return e;
  endfunction

  ev_t z;

  initial begin
    z = '0;
    for (int i = 0; i < 32; i++) arch[i] = '0;
    model_reset();

    // Directed table: one row per cycle, expectations hand-derived.
    add(1, z, 0, 0, 0, 0, 0);
    add(0, cm(64'h80000000, IAddi), 0, 0, 0, 0, 1);
    add(0, cm(64'h80000004, IAddi), 0, 0, 0, 0, 2);
    add(0, cm(64'h80000008, IAddi), 0, 0, 0, 0, 3);
    add(0, cm(64'h80000010, IAddi), 1, 1, 3, 64'h80000010, 3);
    add(0, z, 0, 1, 3, 64'h80000010, 3);
    add(0, cm(64'h0, IAddi), 0, 1, 3, 64'h80000010, 3);
    add(1, z, 0, 0, 0, 0, 0);
    add(0, mk(1, 64'h80000000, IEcall, 0, 0, 1, 0, 64'h80001001, 0, 0), 0, 0, 0, 0, 1);
    add(0, cm(64'h80001000, IAddi), 0, 0, 0, 0, 2);
    add(0, cm(64'h80001004, IAddi), 0, 0, 0, 0, 3);
    add(0, mk(1, 64'h80001008, IEcall, 0, 0, 1, 0, 64'h80001001, 0, 0), 0, 0, 0, 0, 4);
    add(0, cm(64'h80001004, IAddi), 1, 1, 4, 64'h80001004, 4);
    add(1, z, 0, 0, 0, 0, 0);
    add(0, mk(1, 64'h80000000, IMret, 0, 0, 1, 1, 0, 64'h80000104, 0), 0, 0, 0, 0, 1);
    add(0, cm(64'h80000100, IAddi), 1, 1, 5, 64'h80000100, 1);
    add(1, z, 0, 0, 0, 0, 0);
    add(0, mk(1, 64'h80000000, IAddi, 1, 0, 0, 0, 0, 0, 1), 1, 1, 1, 64'h80000000, 0);
    add(1, z, 0, 0, 0, 0, 0);
    add(0, mk(1, 64'h80000000, ISw, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 1);
    add(0, cm(64'h80000004, ISw), 1, 1, 7, 64'h80000004, 1);
    add(1, z, 0, 0, 0, 0, 0);
    add(0, mk(0, 64'h80000040, IAddi, 0, 0, 0, 0, 0, 0, 3), 1, 1, 6, 64'h80000040, 0);
    add(1, z, 0, 0, 0, 0, 0);
    add(0, cm(64'h80000000, IJal), 0, 0, 0, 0, 1);
    add(0, cm(64'h80000100, IAddi), 0, 0, 0, 0, 2);
    add(0, mk(1, 64'h80000200, IAddi, 1, 40, 0, 0, 0, 0, 0), 1, 1, 2, 64'h80000200, 2);
    add(1, z, 0, 0, 0, 0, 0);
    add(0, cm(64'h90000000, IAddi), 0, 0, 0, 0, 1);
    add(0, mk(1, 64'h90000004, IEcall, 0, 0, 1, 0, 64'h100, 0, 0), 0, 0, 0, 0, 2);
    add(1, z, 0, 0, 0, 0, 0);
    add(0, cm(64'h500, IAddi), 0, 0, 0, 0, 1);
    add(1, z, 0, 0, 0, 0, 0);
    add(0, cm(64'h1000, IAddi), 0, 0, 0, 0, 1);
    add(0, mk(0, 64'h0, IAddi, 0, 0, 1, 0, 64'h2000, 0, 0), 0, 0, 0, 0, 1);
    add(0, mk(0, 64'h0, IAddi, 0, 0, 1, 1, 0, 64'h3000, 0), 0, 0, 0, 0, 1);
    add(0, cm(64'h3000, IAddi), 0, 0, 0, 0, 2);
    add(0, cm(64'h3008, IAddi), 1, 1, 3, 64'h3008, 2);

    foreach (tbl[i]) begin
      apply(tbl[i].e, tbl[i].rst);
      check_all($sformatf("tbl%0d", i), tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].p, tbl[i].n);
    end

    // Randomized stream against the reference model.
    apply(z, 1);
    for (int i = 0; i < 3000; i++) begin
      ev_t e;
      logic rst;
      rst = (m_halt && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
      e = gen();
      apply(e, rst);
      check_all($sformatf("rnd%0d", i), m_ev, m_halt, m_ecode, m_epc, m_cnt);
    end

    // Trap raised on the commit that lands on a pending target chains to the new target.
    apply(z, 1);
    apply(mk(1, 64'h100, IEcall, 0, 0, 1, 0, 64'h401, 0, 0), 0);
    check_all("chain0", 0, 0, 0, 0, 1);
    apply(mk(1, 64'h400, IEcall, 0, 0, 1, 0, 64'h802, 0, 0), 0);
    check_all("chain1", 0, 0, 0, 0, 2);
    apply(cm(64'h800, IAddi), 0);
    check_all("chain2", 0, 0, 0, 0, 3);
    apply(cm(64'h804, IAddi), 0);
    check_all("chain3", 0, 0, 0, 0, 4);
    apply(cm(64'h80c, IAddi), 0);
    check_all("chain4", 1, 1, 3, 64'h80c, 4);
    for (int i = 0; i < 3; i++) begin
      apply(mk(0, 64'hfff0, IAddi, 0, 0, 0, 0, 0, 0, 8'h5), 0);
      check_all($sformatf("freeze%0d", i), 0, 1, 3, 64'h80c, 4);
    end

`ifdef DIFF_SHADOW_GPR_EN
    // x5 written but the architectural file never shows it.
    apply(z, 1);
    freeze_arch = 1'b1;
    apply(mk(1, 64'h80000000, IAddi, 1, 5, 0, 0, 0, 0, 0) | ev_t'(0), 0);
    check_all("gpr0", 0, 0, 0, 0, 1);
    apply(z, 0);
    check_all("gpr1", 1, 1, 8, 64'h80000000, 1);
    freeze_arch = 1'b0;
`endif

    apply(z, 1);
    check_all("final_reset", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/diff_commit_checker.md
# diff_commit_checker

In-DUT consumer of the difftest commit stream. It receives the same per-cycle commit, exception and store events that the core hands to the difftest DPI bridge, and checks them for self-consistency in hardware: x0 writes, PC sequencing, trap and `mret` redirect targets, and store pairing. The first violation is latched with a code, PC and commit count, so simulation halts on the exact failing commit without waiting for the software reference model.

## Interface
Parameters:
- `XLEN`, 64: PC and data width.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `instrValid`  in  1  one instruction commits this cycle.
- `the_pc`  in  XLEN  committing PC.
- `instr`  in  32  committing instruction.
- `skip`  in  1  MMIO/skip commit; checked identically.
- `wen`  in  1  GPR write.
- `wdest`  in  8  GPR index.
- `wdata`  in  XLEN  GPR write data.
- `excp_valid`  in  1  trap or `mret` event.
- `isMret`  in  1  qualifies `excp_valid` as `mret`.
- `mtvec`, `mepc`  in  XLEN  CSR values as sampled this cycle.
- `storeValid`  in  8  nonzero means a store event this cycle.
- `gprFlat`  in  32*XLEN  architectural GPRs; `gprFlat[i*XLEN +: XLEN]` = x[i].
- `errValid`  out  1  one-cycle pulse on first error.
- `errSticky`  out  1  latched error.
- `errCode`  out  4  first error code.
- `errPc`  out  XLEN  PC of offending commit.
- `commitCnt`  out  64  commits accepted before the error.

## Operation
Error codes:
- 1 `X0_WRITE`: `wen` with `wdest==0`.
- 2 `BAD_DEST`: `wen` with `wdest>31`.
- 3 `PC_SEQ`: previous commit was a non-control op and `the_pc != prevPc+4`.
- 4 `TRAP_TGT`: first commit after a trap, with `the_pc != {mtvecLatched[XLEN-1:2],2'b00}`.
- 5 `MRET_TGT`: first commit after `mret`, with `the_pc != mepcLatched`.
- 6 `STORE_ORPHAN`: `storeValid!=0` without a committing store (`instr[6:0]==7'b0100011`).
- 7 `STORE_MISSING`: a store commits with `storeValid==0`.
- 8 `GPR_MISMATCH`: only when the shadow-GPR feature is compiled in.

Control ops, which skip the `PC_SEQ` check, are opcodes `1100011`, `1101111`, `1100111` and `1110011`.

FSM states:
- IDLE: no commit seen yet. The first commit sets `prevPc` and `prevCtl` and is not PC-checked. Goes to RUN.
- RUN: normal checking. `excp_valid & ~isMret` latches `mtvec` and goes to TRAP_PEND. `excp_valid & isMret` latches `mepc` and goes to MRET_PEND.
- TRAP_PEND and MRET_PEND: wait for the next commit. That commit is checked against the latched target instead of `PC_SEQ`, then the FSM returns to RUN.
- HALT: entered on any error. No further checks; all outputs are frozen until `reset`.

Rules:
- `excp_valid` coinciding with `instrValid`: that commit is the trapping instruction. It is checked under the current state first, then the pending state is entered.
- `excp_valid` while already pending: the new target overwrites the old one.
- Several errors on one commit: the lowest code wins.
- `commitCnt` increments on each error-free `instrValid`. It wraps modulo 2^64.

## Timing
- Checks are combinational on the event cycle. Error registers update at the next `clock` edge, so the error flag appears 1 cycle after the offending commit.
- `errValid` is high for exactly one cycle, the cycle HALT is entered.
- `GPR_MISMATCH` is detected 2 cycles after the write commit: the comparison runs 1 cycle after the shadow update, against `gprFlat`.
- Reset values:
  - `errValid`, `errSticky`: 0.
  - `errCode`: 0.
  - `errPc`: 0.
  - `commitCnt`: 0.
  - FSM: IDLE.
  - Latched targets and `prevPc`: 0.
  - Shadow GPRs: 0.
- `reset` in any state, including HALT or pending, returns the block to IDLE in the same edge. A pending redirect is discarded.

## Configuration
- `DIFF_SHADOW_GPR_EN` defined:
  - A 31×XLEN shadow file (x1..x31) updates on each `instrValid & wen & wdest in 1..31`.
  - On the cycle after any commit, every shadow entry is compared with `gprFlat`. Any difference raises code 8, with `errPc` = PC of that commit.
  - x0 of `gprFlat` must be 0, otherwise code 8.
- Undefined: no shadow storage or compare logic is built, and code 8 never occurs.

## Test plan
- Commits at 0x80000000, 0x80000004, 0x80000008 (`addi`), then one at 0x80000010 -> `errCode=3`, `errPc=0x80000010`, `commitCnt=3`, `errValid` for 1 cycle.
- `ecall` commit with `excp_valid=1` and `mtvec=0x80001001`; next commit at 0x80001000 -> no error. Repeat with the next commit at 0x80001004 -> `errCode=4`.
- `mret` event with `mepc=0x80000104`; next commit at 0x80000100 -> `errCode=5`.
- `wen=1`, `wdest=0` together with `storeValid=1` on a non-store commit -> `errCode=1` (lowest code wins).
- With `DIFF_SHADOW_GPR_EN`: commit writes x5=0xDEAD, `gprFlat` x5 stays 0 -> `errCode=8` two cycles later.
- Error latched, then `reset` pulse for 1 cycle -> all outputs 0, FSM IDLE, first new commit not PC-checked.
